// File: rtl/if_fsk_demod.sv
// ============================================================================
// if_fsk_demod
// ----------------------------------------------------------------------------
// Binary FSK demodulator for the digital IF path after the mixer ADC. The
// signed IF samples go through a hysteresis slicer. Every change of the
// slicer output is a zero-crossing. The crossings of each symbol are counted,
// and a high count decides '1', a low count decides '0'.
// A preamble-search FSM keeps the bit stream gated until it has seen an
// alternating preamble. It then raises lock and forwards one bit per symbol.
//
// Ports
//   clk           system / sampling clock
//   rst           synchronous reset, active high
//   pd            power-down, active high, synchronous clear (highest priority)
//   sample_i      signed IF sample, DATA_W bits
//   sample_vld_i  sample_i is valid this cycle
//   sync_i        re-align the symbol boundary (one-cycle pulse)
//   bit_o         demodulated bit
//   bit_vld_o     one-cycle strobe qualifying bit_o
//   zc_count_o    crossing count of the last completed symbol
//   lock_o        high while the FSM is locked onto a preamble
// ============================================================================
module if_fsk_demod #(
    parameter int DATA_W  = 8,
    parameter int SPS     = 400,
    parameter int CNT_W   = 9,
    parameter int ZC_W    = 6,
    parameter int HYST    = 4,
    parameter int ZC_THR  = 8,
    parameter int PRE_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pd,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_vld_i,
    input  logic              sync_i,
    output logic              bit_o,
    output logic              bit_vld_o,
    output logic [ZC_W-1:0]   zc_count_o,
    output logic              lock_o
);

    localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] HYST_NEG = DATA_W'(-HYST);
    localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(SPS - 1);
    localparam logic [ZC_W-1:0]          ZC_MAX   = '1;
    localparam logic [ZC_W-1:0]          ZC_THR_V = ZC_W'(ZC_THR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state_reg;
    logic                s_reg;
    logic [CNT_W-1:0]    sym_cnt_reg;
    logic [ZC_W-1:0]     zc_cnt_reg;
    logic [PRE_LEN-1:0]  pre_reg;
    logic                bit_reg;
    logic                bit_vld_reg;
    logic [ZC_W-1:0]     zc_out_reg;
    logic                lock_reg;

    // Both accepted preamble patterns. Bit 0 holds the newest symbol decision.
    logic [PRE_LEN-1:0]  pat_a;   // ...1010 (newest bit 0)
    logic [PRE_LEN-1:0]  pat_b;   // ...0101 (newest bit 1)

    for (genvar gi = 0; gi < PRE_LEN; gi++) begin : g_pat
        assign pat_a[gi] = (gi % 2 == 1);
        assign pat_b[gi] = (gi % 2 == 0);
    end

    logic signed [DATA_W-1:0] sample_s;
    logic                     s_next;
    logic                     crossing;
    logic                     boundary;
    logic [ZC_W-1:0]          n_val;
    logic                     b_val;
    logic [PRE_LEN-1:0]       pre_next;
    logic                     pre_hit;

    assign sample_s = $signed(sample_i);

    always_comb begin
        // Hysteresis slicer: values inside [-HYST, +HYST] keep the old level.
        s_next = s_reg;
        if (sample_s > HYST_POS) begin
            s_next = 1'b1;
        end else if (sample_s < HYST_NEG) begin
            s_next = 1'b0;
        end
        crossing = sample_vld_i && (s_next != s_reg);

        // Crossing count including this sample, saturating at all-ones.
        n_val = zc_cnt_reg;
        if (crossing && (zc_cnt_reg != ZC_MAX)) begin
            n_val = zc_cnt_reg + ZC_W'(1);
        end

        // A sync on the last sample re-aligns instead of closing the symbol.
        boundary = sample_vld_i && !sync_i && (sym_cnt_reg == LAST_CNT);
        b_val    = (n_val >= ZC_THR_V);
        pre_next = {pre_reg[PRE_LEN-2:0], b_val};
        pre_hit  = (pre_next == pat_a) || (pre_next == pat_b);
    end

    always_ff @(posedge clk) begin
        if (rst || pd) begin
            state_reg   <= IDLE;
            s_reg       <= 1'b0;
            sym_cnt_reg <= '0;
            zc_cnt_reg  <= '0;
            pre_reg     <= '0;
            bit_reg     <= 1'b0;
            bit_vld_reg <= 1'b0;
            zc_out_reg  <= '0;
            lock_reg    <= 1'b0;
        end else begin
            bit_vld_reg <= 1'b0;

            if (state_reg == IDLE) begin
                state_reg <= SEARCH;
            end

            if (sample_vld_i) begin
                s_reg <= s_next;
            end

            if (sync_i) begin
                // Discard the partial symbol. A valid sync sample is sample 0
                // of the new symbol, and its crossing starts the new count.
                sym_cnt_reg <= sample_vld_i ? CNT_W'(1) : '0;
                zc_cnt_reg  <= ZC_W'(crossing);
            end else if (sample_vld_i) begin
                if (boundary) begin
                    sym_cnt_reg <= '0;
                    zc_cnt_reg  <= '0;
                end else begin
                    sym_cnt_reg <= sym_cnt_reg + CNT_W'(1);
                    zc_cnt_reg  <= n_val;
                end
            end

            if (boundary) begin
                zc_out_reg <= n_val;
                case (state_reg)
                    SEARCH: begin
                        pre_reg <= pre_next;
                        if (pre_hit) begin
                            state_reg <= LOCKED;
                            lock_reg  <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (n_val == '0) begin
                            // No crossings at all: the carrier is gone.
                            state_reg <= SEARCH;
                            lock_reg  <= 1'b0;
                            pre_reg   <= '0;
                        end else begin
                            bit_reg     <= b_val;
                            bit_vld_reg <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bit_o      = bit_reg;
    assign bit_vld_o  = bit_vld_reg;
    assign zc_count_o = zc_out_reg;
    assign lock_o     = lock_reg;

endmodule
